// File: rtl/framing_overlap.sv
// framing_overlap: takes a sparse stream of signed samples into a circular buffer and
// emits fixed-length frames from it. The start of each frame is HOP samples after the
// start of the previous one, so frames can overlap, abut or skip samples. Every frame
// element is sign-extended to O_BW bits and held for CADENCE_CYC cycles.
//
// Ports:
//   clk_i      - clock
//   rst_n_i    - asynchronous active-low reset
//   en_i       - enable; when low all state is frozen and valid_o/last_o read 0
//   clr_i      - synchronous clear of buffer state and overflow flag (only while en_i=1)
//   data_i     - signed input sample, I_BW bits
//   valid_i    - input sample strobe, at most one sample per cycle
//   data_o     - sign-extended frame element (registered)
//   valid_o    - frame element valid (registered)
//   last_o     - final element of a frame (registered)
//   overflow_o - sticky flag: a sample was dropped because the buffer was full
module framing_overlap #(
    parameter int unsigned I_BW        = 9,
    parameter int unsigned O_BW        = 16,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned HOP         = 160,
    parameter int unsigned CADENCE_CYC = 1,
    parameter int unsigned BUF_DEPTH   = 512
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            last_o,
    output logic            overflow_o
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned IW = $clog2(FRAME_LEN);
    localparam int unsigned CW = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;
    localparam int unsigned SW = $clog2(HOP + 1);

    localparam logic [FW-1:0] FillFull  = FW'(BUF_DEPTH);
    localparam logic [FW-1:0] FrameFill = FW'(FRAME_LEN);
    localparam logic [IW-1:0] IdxLast   = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CadLast   = CW'(CADENCE_CYC - 1);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   base_q, base_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [SW-1:0]   skip_q, skip_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cad_q, cad_d;
    logic            ovf_q, ovf_d;
    logic [O_BW-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic [I_BW-1:0] mem_q [BUF_DEPTH];
    logic            wr_en;
    logic            acc;
    logic [FW-1:0]   fill_acc;
    logic [AW-1:0]   rd_addr;
    logic [I_BW-1:0] rd_data;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            base_q  <= '0;
            fill_q  <= '0;
            skip_q  <= '0;
            idx_q   <= '0;
            cad_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            base_q  <= base_d;
            fill_q  <= fill_d;
            skip_q  <= skip_d;
            idx_q   <= idx_d;
            cad_q   <= cad_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Sample storage has no reset; fill tracks which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Next-state: sample acceptance, element sequencing and hop update
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        base_d   = base_q;
        fill_d   = fill_q;
        skip_d   = skip_q;
        idx_d    = idx_q;
        cad_d    = cad_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        acc      = 1'b0;
        fill_acc = fill_q;

        if (en_i) begin
            if (clr_i) begin
                state_d = StIdle;
                wptr_d  = '0;
                base_d  = '0;
                fill_d  = '0;
                skip_d  = '0;
                idx_d   = '0;
                cad_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                if (valid_i) begin
                    if (skip_q != '0) begin
                        skip_d = skip_q - SW'(1);
                    end else if (fill_q == FillFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        acc    = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                    end
                end
                fill_acc = fill_q + FW'(acc);
                fill_d   = fill_acc;

                unique case (state_q)
                    StIdle: begin
                        if (fill_acc >= FrameFill) begin
                            state_d = StEmit;
                            idx_d   = '0;
                            cad_d   = '0;
                        end
                    end
                    StEmit: begin
                        if (cad_q == CadLast) begin
                            cad_d = '0;
                            if (idx_q == IdxLast) begin
                                idx_d = '0;
                                // Hop counts a sample accepted this same cycle.
                                if (32'(fill_acc) >= HOP) begin
                                    base_d = base_q + AW'(HOP);
                                    fill_d = fill_acc - FW'(HOP);
                                end else begin
                                    // Not enough buffered: discard the rest of the hop
                                    // as it arrives and restart at the write pointer.
                                    skip_d = SW'(HOP - 32'(fill_acc));
                                    base_d = wptr_d;
                                    fill_d = '0;
                                end
                                state_d = (fill_d >= FrameFill) ? StEmit : StIdle;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            cad_d = cad_q + CW'(1);
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Outputs are loaded from the next element so they line up with the FSM. The element
    // read is always below fill, so it never collides with a same-cycle write.
    always_comb begin
        rd_addr = base_d + AW'(idx_d);
        rd_data = mem_q[rd_addr];
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (en_i && !clr_i && (state_d == StEmit)) begin
            valid_d = 1'b1;
            last_d  = (idx_d == IdxLast);
            data_d  = O_BW'($signed(rd_data));
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_framing_overlap.sv
// Bench for framing_overlap: four instances (overlap, skip, cadence/overflow, defaults)
// with a per-instance position model feeding an expected-element scoreboard.
module tb_framing_overlap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [8:0]  din  [4];
    logic        vin  [4];
    logic        en   [4];
    logic        clr  [4];
    logic [15:0] dout [4];
    logic        vld  [4];
    logic        lst  [4];
    logic        ovf  [4];

    framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(8), .HOP(4), .CADENCE_CYC(1),
                      .BUF_DEPTH(16)) u_overlap (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en[0]), .clr_i(clr[0]), .data_i(din[0]),
        .valid_i(vin[0]), .data_o(dout[0]), .valid_o(vld[0]), .last_o(lst[0]),
        .overflow_o(ovf[0]));

    framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(8), .HOP(12), .CADENCE_CYC(1),
                      .BUF_DEPTH(16)) u_skip (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en[1]), .clr_i(clr[1]), .data_i(din[1]),
        .valid_i(vin[1]), .data_o(dout[1]), .valid_o(vld[1]), .last_o(lst[1]),
        .overflow_o(ovf[1]));

    framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(8), .HOP(4), .CADENCE_CYC(4),
                      .BUF_DEPTH(16)) u_cad (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en[2]), .clr_i(clr[2]), .data_i(din[2]),
        .valid_i(vin[2]), .data_o(dout[2]), .valid_o(vld[2]), .last_o(lst[2]),
        .overflow_o(ovf[2]));

    framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(256), .HOP(160), .CADENCE_CYC(1),
                      .BUF_DEPTH(512)) u_dflt (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en[3]), .clr_i(clr[3]), .data_i(din[3]),
        .valid_i(vin[3]), .data_o(dout[3]), .valid_o(vld[3]), .last_o(lst[3]),
        .overflow_o(ovf[3]));

    int fl [4] = '{8, 8, 8, 256};
    int hp [4] = '{4, 12, 4, 160};
    int cd [4] = '{1, 1, 4, 1};

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t       expq [4][$];
    logic [8:0] strm [4][$];
    int         cnt  [4];
    bit         chk  [4];
    int         checks;
    int         errors;

    function automatic logic [15:0] sext(logic [8:0] s);
        return {{7{s[8]}}, s};
    endfunction

    task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a frame k covers accepted-stream positions k*HOP .. k*HOP+FRAME_LEN-1.
    task automatic model_push(int i, logic [8:0] v);
        int n;
        int k;
        exp_t e;
        strm[i].push_back(v);
        n = strm[i].size() - 1;
        if (n >= fl[i] - 1 && ((n - (fl[i] - 1)) % hp[i]) == 0) begin
            k = (n - fl[i] + 1) / hp[i];
            for (int j = 0; j < fl[i]; j++) begin
                e.d = sext(strm[i][k * hp[i] + j]);
                e.l = (j == fl[i] - 1);
                expq[i].push_back(e);
            end
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 4; i++) begin
            if (chk[i] && vld[i]) begin
                checks++;
                assert (expq[i].size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid[%0d] observed valid_o=1 expected nothing", i);
                end
                if (expq[i].size() > 0) begin
                    checks++;
                    assert (dout[i] === expq[i][0].d) else begin
                        errors++;
                        $error("FAIL data[%0d] observed=%h expected=%h", i, dout[i],
                               expq[i][0].d);
                    end
                    checks++;
                    assert (lst[i] === expq[i][0].l) else begin
                        errors++;
                        $error("FAIL last[%0d] observed=%b expected=%b", i, lst[i],
                               expq[i][0].l);
                    end
                    cnt[i]++;
                    if (cnt[i] == cd[i]) begin
                        void'(expq[i].pop_front());
                        cnt[i] = 0;
                    end
                end
            end else if (chk[i]) begin
                checks++;
                assert (lst[i] === 1'b0) else begin
                    errors++;
                    $error("FAIL last_idle[%0d] observed=%b expected=0", i, lst[i]);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic drive(int i, logic [8:0] v, bit push);
        din[i] = v;
        vin[i] = 1'b1;
        if (push) model_push(i, v);
        step();
        vin[i] = 1'b0;
    endtask

    task automatic drain(int i, int maxc);
        int c = 0;
        while (expq[i].size() != 0 && c < maxc) begin
            step();
            c++;
        end
        checks++;
        assert (expq[i].size() == 0) else begin
            errors++;
            $error("FAIL drain[%0d] observed %0d pending expected 0", i, expq[i].size());
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) begin
            expq[i].delete();
            strm[i].delete();
            cnt[i] = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
            en[i]  = 1'b1;
            clr[i] = 1'b0;
            cnt[i] = 0;
            chk[i] = 1'b1;
        end

        // Reset held with valid_i toggling: all outputs stay 0
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                vin[i] = ~vin[i];
                din[i] = 9'h1AB;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                chk_eq("rst_data", 32'(dout[i]), 32'h0);
                chk_eq("rst_valid", 32'(vld[i]), 32'h0);
                chk_eq("rst_last", 32'(lst[i]), 32'h0);
                chk_eq("rst_ovf", 32'(ovf[i]), 32'h0);
            end
        end
        for (int i = 0; i < 4; i++) vin[i] = 1'b0;
        rst_n = 1'b1;
        step();

        // Defaults: no output before 256 samples; sign extension of the first elements
        drive(3, 9'h1FF, 1'b1);
        drive(3, 9'h100, 1'b1);
        drive(3, 9'h0FF, 1'b1);
        for (int j = 3; j < 255; j++) drive(3, 9'($urandom), 1'b1);
        idle(3);
        chk_eq("dflt_no_valid_before_256", 32'(vld[3]), 32'h0);
        drive(3, 9'h055, 1'b1);
        chk_eq("dflt_first_valid", 32'(vld[3]), 32'h1);
        chk_eq("sext_1ff", 32'(dout[3]), 32'h0000FFFF);
        step();
        chk_eq("sext_100", 32'(dout[3]), 32'h0000FF00);
        step();
        chk_eq("sext_0ff", 32'(dout[3]), 32'h000000FF);
        drain(3, 400);
        idle(5);

        // Overlap: samples 1..16 one every 4 cycles
        for (int v = 1; v <= 16; v++) begin
            drive(0, 9'(v), 1'b1);
            idle(3);
        end
        drain(0, 50);
        idle(4);
        chk_eq("overlap_no_ovf", 32'(ovf[0]), 32'h0);

        // Skip: samples 1..32 one every 4 cycles, HOP > FRAME_LEN
        for (int v = 1; v <= 32; v++) begin
            drive(1, 9'(v), 1'b1);
            idle(3);
        end
        drain(1, 50);
        idle(4);

        // Cadence: 8 back-to-back samples, 32 consecutive valid cycles
        for (int v = 0; v < 8; v++) drive(2, 9'(v * 67 + 200), 1'b1);
        chk_eq("cad_first_valid", 32'(vld[2]), 32'h1);
        for (int k = 1; k < 32; k++) begin
            step();
            chk_eq("cad_no_bubble", 32'(vld[2]), 32'h1);
        end
        step();
        chk_eq("cad_frame_end", 32'(vld[2]), 32'h0);

        // Enable low for 5 cycles during element 3; valid_i offered meanwhile is ignored
        for (int v = 8; v < 12; v++) drive(2, 9'(v * 29 + 5), 1'b1);
        idle(13);
        en[2]  = 1'b0;
        din[2] = 9'h1AA;
        vin[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_eq("en_low_valid", 32'(vld[2]), 32'h0);
            chk_eq("en_low_hold", 32'(dout[2]), 32'(sext(strm[2][7])));
        end
        en[2]  = 1'b1;
        vin[2] = 1'b0;
        drain(2, 60);
        for (int v = 12; v < 16; v++) drive(2, 9'(v * 13 + 300), 1'b1);
        drain(2, 60);
        idle(4);

        // Overflow with back-to-back feed, then clear
        chk[2] = 1'b0;
        chk_eq("ovf_before", 32'(ovf[2]), 32'h0);
        for (int v = 0; v < 40; v++) drive(2, 9'(v), 1'b0);
        chk_eq("ovf_set", 32'(ovf[2]), 32'h1);
        idle(3);
        chk_eq("ovf_sticky", 32'(ovf[2]), 32'h1);
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        chk_eq("clr_ovf", 32'(ovf[2]), 32'h0);
        chk_eq("clr_valid", 32'(vld[2]), 32'h0);
        expq[2].delete();
        strm[2].delete();
        cnt[2] = 0;
        chk[2] = 1'b1;
        idle(3);
        for (int v = 0; v < 7; v++) drive(2, 9'(v * 41 + 17), 1'b1);
        idle(3);
        chk_eq("clr_buffer_empty", 32'(vld[2]), 32'h0);
        drive(2, 9'h133, 1'b1);
        drain(2, 60);
        idle(4);

        // Reset during element 5: outputs drop at once, next frame is post-reset only
        for (int v = 0; v < 4; v++) drive(0, 9'(9'h150 + 9'(v)), 1'b1);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst_valid", 32'(vld[0]), 32'h0);
        chk_eq("async_rst_data", 32'(dout[0]), 32'h0);
        chk_eq("async_rst_last", 32'(lst[0]), 32'h0);
        flush_all();
        step();
        rst_n = 1'b1;
        idle(2);
        for (int v = 0; v < 8; v++) drive(0, 9'(9'h1C0 + 9'(v * 3)), 1'b1);
        drain(0, 40);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
